// File: rtl/mul_job_dispatcher.sv
`timescale 1ns/1ps
// Job FIFO and launch sequencer for the shift-add multiplier CPU; returns results in order.
// Define MUL_DISPATCH_CYCLE_COUNT_EN to add out_cycles (WAIT counter captured with the result).
module mul_job_dispatcher #(
  parameter int unsigned BIT_WIDTH      = 16,
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 500,
  parameter int unsigned RST_CYCLES     = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [BIT_WIDTH-1:0] in_a,
  input  logic [BIT_WIDTH-1:0] in_b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [BIT_WIDTH-1:0] out_result,
  output logic                 out_error,
  output logic                 busy,
  output logic                 cpu_start,
  output logic [BIT_WIDTH-1:0] cpu_operand_a,
  output logic [BIT_WIDTH-1:0] cpu_operand_b,
  input  logic [BIT_WIDTH-1:0] cpu_result,
  input  logic                 cpu_done,
  output logic                 cpu_rst_n
`ifdef MUL_DISPATCH_CYCLE_COUNT_EN
  ,
  output logic [15:0]          out_cycles
`endif
);

  localparam int unsigned PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned WAIT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned RST_W  = (RST_CYCLES > 1) ? $clog2(RST_CYCLES + 1) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT,
    S_HOLD,
    S_CPU_RST,
    S_SETTLE
  } state_t;

  state_t               r_state;
  state_t               w_next;

  logic [BIT_WIDTH-1:0] r_fifo_a [FIFO_DEPTH];
  logic [BIT_WIDTH-1:0] r_fifo_b [FIFO_DEPTH];
  logic [PTR_W-1:0]     r_wr_ptr;
  logic [PTR_W-1:0]     r_rd_ptr;
  logic [CNT_W-1:0]     r_count;

  logic [BIT_WIDTH-1:0] r_op_a;
  logic [BIT_WIDTH-1:0] r_op_b;
  logic [BIT_WIDTH-1:0] r_result;
  logic                 r_error;
  logic [WAIT_W-1:0]    r_wait_cnt;
  logic [RST_W-1:0]     r_rst_cnt;

  logic                 w_full;
  logic                 w_empty;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_timeout;
  logic                 w_rst_last;

  // Full is judged on the registered count only, so a same-cycle pop never frees a slot.
  assign w_full     = (r_count == CNT_W'(FIFO_DEPTH));
  assign w_empty    = (r_count == '0);
  assign w_push     = in_valid && in_ready;
  assign w_pop      = (r_state == S_IDLE) && !w_empty;
  assign w_timeout  = (r_wait_cnt == WAIT_W'(TIMEOUT_CYCLES - 1));
  assign w_rst_last = (r_rst_cnt == RST_W'(RST_CYCLES - 1));

  assign in_ready      = rst_n && !w_full;
  assign out_valid     = (r_state == S_HOLD);
  assign out_result    = r_result;
  assign out_error     = r_error;
  assign busy          = (r_state != S_IDLE) || !w_empty;
  assign cpu_start     = (r_state == S_LAUNCH);
  assign cpu_operand_a = r_op_a;
  assign cpu_operand_b = r_op_b;
  assign cpu_rst_n     = rst_n && (r_state != S_CPU_RST);

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_a[r_wr_ptr] <= in_a;
      r_fifo_b[r_wr_ptr] <= in_b;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (!w_empty) w_next = S_LAUNCH;
      S_LAUNCH:  w_next = S_WAIT;
      S_WAIT:    if (cpu_done || w_timeout) w_next = S_HOLD;
      S_HOLD:    if (out_ready) w_next = S_CPU_RST;
      S_CPU_RST: if (w_rst_last) w_next = S_SETTLE;
      S_SETTLE:  w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

`ifdef MUL_DISPATCH_CYCLE_COUNT_EN
  logic [15:0] r_cycles;
  assign out_cycles = r_cycles;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                           r_cycles <= '0;
    else if ((r_state == S_WAIT) && (cpu_done || w_timeout)) r_cycles <= 16'(r_wait_cnt);
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op_a     <= '0;
      r_op_b     <= '0;
      r_result   <= '0;
      r_error    <= 1'b0;
      r_wait_cnt <= '0;
      r_rst_cnt  <= '0;
    end else begin
      if (w_pop) begin
        r_op_a <= r_fifo_a[r_rd_ptr];
        r_op_b <= r_fifo_b[r_rd_ptr];
      end
      case (r_state)
        S_LAUNCH: r_wait_cnt <= '0;
        S_WAIT: begin
          r_wait_cnt <= r_wait_cnt + 1'b1;
          // done takes priority over a coincident timeout
          if (cpu_done) begin
            r_result <= cpu_result;
            r_error  <= 1'b0;
          end else if (w_timeout) begin
            r_result <= '0;
            r_error  <= 1'b1;
          end
        end
        S_HOLD:    if (out_ready) r_rst_cnt <= '0;
        S_CPU_RST: r_rst_cnt <= r_rst_cnt + 1'b1;
        default:   ;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_job_dispatcher.sv
`timescale 1ns/1ps
// Bench for mul_job_dispatcher: behavioural CPU stand-in plus an in-order product scoreboard.
module tb_mul_job_dispatcher;

  localparam int W    = 16;
  localparam int DEPTH = 4;
  localparam int TMO  = 500;
  localparam int RSTC = 2;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_a = '0;
  logic [W-1:0] in_b = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_result;
  logic         out_error;
  logic         busy;
  logic         cpu_start;
  logic [W-1:0] cpu_operand_a;
  logic [W-1:0] cpu_operand_b;
  logic [W-1:0] cpu_result;
  logic         cpu_done;
  logic         cpu_rst_n;
`ifdef MUL_DISPATCH_CYCLE_COUNT_EN
  logic [15:0]  out_cycles;
`endif

  always #5 clk = ~clk;

  mul_job_dispatcher #(
    .BIT_WIDTH(W), .FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO), .RST_CYCLES(RSTC)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result), .out_error(out_error),
    .busy(busy), .cpu_start(cpu_start), .cpu_operand_a(cpu_operand_a), .cpu_operand_b(cpu_operand_b),
    .cpu_result(cpu_result), .cpu_done(cpu_done), .cpu_rst_n(cpu_rst_n)
`ifdef MUL_DISPATCH_CYCLE_COUNT_EN
    , .out_cycles(out_cycles)
`endif
  );

  // Behavioural CPU: product after a random latency, done held until reset; m_hang suppresses done.
  logic         m_hang = 1'b0;
  logic         m_busy;
  logic [W-1:0] m_res;
  logic         m_done;
  int           m_cnt;
  int           m_lat;
  assign cpu_result = m_res;
  assign cpu_done   = m_done;

  always @(posedge clk or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      m_busy <= 1'b0; m_done <= 1'b0; m_res <= '0; m_cnt <= 0; m_lat <= 4;
    end else if (cpu_start) begin
      m_busy <= 1'b1; m_cnt <= 0; m_lat <= $urandom_range(4, 24);
      m_res  <= W'(cpu_operand_a * cpu_operand_b);
    end else if (m_busy && !m_hang) begin
      m_cnt <= m_cnt + 1;
      if (m_cnt + 1 >= m_lat) begin
        m_done <= 1'b1; m_busy <= 1'b0;
      end
    end
  end

  int n_pass = 0;
  int n_checks = 0;
  logic [W-1:0] exp_q[$];
  logic [W:0]   obs_q[$];
  int           obs_cyc_q[$];
  int           ref_cyc_q[$];
  int           start_cycles = 0;
  int           rstlow_cycles = 0;
  int           tb_cnt = 0;
  bit           armed = 1'b0;

  function automatic logic [W-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [2*W-1:0] p;
    p = a * b;
    return p[W-1:0];
  endfunction

  // Output-side monitor, sampled mid-cycle on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (cpu_start) start_cycles++;
        if (!cpu_rst_n) rstlow_cycles++;
        if (out_valid && out_ready) begin
          obs_q.push_back({out_error, out_result});
`ifdef MUL_DISPATCH_CYCLE_COUNT_EN
          obs_cyc_q.push_back(int'(out_cycles));
`endif
        end
        if (cpu_start) begin
          tb_cnt = 0; armed = 1'b1;
        end else if (armed) begin
          if (cpu_done) begin
            ref_cyc_q.push_back(tb_cnt); armed = 1'b0;
          end else tb_cnt++;
        end
      end else armed = 1'b0;
    end
  end

  task automatic push_job(input logic [W-1:0] a, input logic [W-1:0] b, input int max_wait, output bit ok);
    in_a = a; in_b = b; in_valid = 1'b1; ok = 1'b0;
    for (int k = 0; k < max_wait; k++) begin
      if (in_ready) ok = 1'b1;
      @(posedge clk); #1;
      if (ok) break;
    end
    in_valid = 1'b0;
    if (ok) exp_q.push_back(ref_mul(a, b));
  endtask

  task automatic wait_results(input int n, input int max_cycles);
    for (int k = 0; k < max_cycles && obs_q.size() < n; k++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic clear_logs;
    exp_q.delete(); obs_q.delete(); obs_cyc_q.delete(); ref_cyc_q.delete();
    start_cycles = 0; rstlow_cycles = 0;
  endtask

  task automatic test_reset;
    logic [3*W+5:0] got;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    got = {in_ready, out_valid, out_error, cpu_start, busy, cpu_rst_n, out_result, cpu_operand_a, cpu_operand_b};
    n_checks++;
    if (got !== '0) $display("FAIL reset_values got=%h exp=0", got); else n_pass++;
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if ({in_ready, cpu_rst_n, busy, out_valid} !== 4'b1100)
      $display("FAIL reset_release got=%b exp=1100", {in_ready, cpu_rst_n, busy, out_valid});
    else n_pass++;
  endtask

  task automatic test_single;
    bit ok;
    clear_logs();
    out_ready = 1'b1;
    push_job(16'd3, 16'd5, 10, ok);
    n_checks++;
    if (!ok || cpu_start !== 1'b0 || busy !== 1'b1)
      $display("FAIL single_accept ok=%0b start=%b busy=%b exp ok=1 start=0 busy=1", ok, cpu_start, busy);
    else n_pass++;
    @(posedge clk); #1;
    n_checks++;
    if ({cpu_start, cpu_operand_a, cpu_operand_b} !== {1'b1, 16'd3, 16'd5})
      $display("FAIL single_launch start=%b a=%0d b=%0d exp 1,3,5", cpu_start, cpu_operand_a, cpu_operand_b);
    else n_pass++;
    wait_results(1, 200);
    repeat (10) @(posedge clk);
    #1;
    n_checks++;
    if (obs_q.size() != 1) $display("FAIL single_count got=%0d exp=1", obs_q.size());
    else begin
      if (obs_q[0] !== {1'b0, ref_mul(16'd3, 16'd5)})
        $display("FAIL single_result got=%h exp=%h", obs_q[0], {1'b0, ref_mul(16'd3, 16'd5)});
      else n_pass++;
    end
    n_checks++;
    if (start_cycles != 1) $display("FAIL single_start_width got=%0d exp=1", start_cycles); else n_pass++;
    n_checks++;
    if (rstlow_cycles != RSTC) $display("FAIL single_cpu_rst_len got=%0d exp=%0d", rstlow_cycles, RSTC); else n_pass++;
`ifdef MUL_DISPATCH_CYCLE_COUNT_EN
    n_checks++;
    if (obs_cyc_q.size() != 1 || ref_cyc_q.size() != 1 || obs_cyc_q[0] != ref_cyc_q[0])
      $display("FAIL single_cycles got=%p exp=%p", obs_cyc_q, ref_cyc_q);
    else n_pass++;
`endif
  endtask

  task automatic test_back_to_back;
    logic [W-1:0] av [6] = '{16'd7, 16'd12, 16'd0, 16'd5, 16'd1, 16'd42};
    logic [W-1:0] bv [6] = '{16'd8, 16'd10, 16'd5, 16'd0, 16'd42, 16'd1};
    bit ok;
    bit seen_ready;
    int first_obs;
    clear_logs();
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      push_job(av[i], bv[i], 10, ok);
      n_checks++;
      if (!ok) $display("FAIL b2b_accept%0d got=0 exp=1", i); else n_pass++;
    end
    in_a = av[5]; in_b = bv[5]; in_valid = 1'b1; seen_ready = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (in_ready) seen_ready = 1'b1;
      @(posedge clk); #1;
    end
    n_checks++;
    if (seen_ready || !busy) $display("FAIL b2b_full in_ready_seen=%0b busy=%b exp 0,1", seen_ready, busy);
    else n_pass++;
    out_ready = 1'b1; ok = 1'b0;
    for (int k = 0; k < 300; k++) begin
      if (in_ready) ok = 1'b1;
      @(posedge clk); #1;
      if (ok) break;
    end
    in_valid = 1'b0;
    first_obs = obs_q.size();
    if (ok) exp_q.push_back(ref_mul(av[5], bv[5]));
    n_checks++;
    if (!ok || first_obs < 1) $display("FAIL b2b_sixth ok=%0b results_before=%0d exp ok=1 results>=1", ok, first_obs);
    else n_pass++;
    wait_results(6, 600);
    n_checks++;
    if (obs_q.size() != 6) $display("FAIL b2b_count got=%0d exp=6", obs_q.size()); else n_pass++;
    for (int i = 0; i < 6 && i < obs_q.size() && i < exp_q.size(); i++) begin
      n_checks++;
      if (obs_q[i] !== {1'b0, exp_q[i]}) $display("FAIL b2b_result%0d got=%h exp=%h", i, obs_q[i], {1'b0, exp_q[i]});
      else n_pass++;
    end
  endtask

  task automatic test_backpressure;
    bit ok;
    bit stable;
    clear_logs();
    out_ready = 1'b0;
    push_job(16'd255, 16'd255, 10, ok);
    for (int k = 0; k < 200 && !out_valid; k++) begin
      @(posedge clk); #1;
    end
    stable = out_valid;
    for (int k = 0; k < 10; k++) begin
      if (!out_valid || out_result !== 16'd65025 || out_error) stable = 1'b0;
      @(posedge clk); #1;
    end
    n_checks++;
    if (!stable || obs_q.size() != 0)
      $display("FAIL bp_hold stable=%0b results=%0d exp stable=1 results=0", stable, obs_q.size());
    else n_pass++;
    out_ready = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (out_valid !== 1'b0) $display("FAIL bp_valid_drop got=%b exp=0", out_valid); else n_pass++;
    repeat (30) @(posedge clk);
    #1;
    n_checks++;
    if (obs_q.size() != 1 || obs_q[0] !== {1'b0, exp_q[0]})
      $display("FAIL bp_result count=%0d first=%h exp 1,%h", obs_q.size(), obs_q.size() ? obs_q[0] : '0, {1'b0, exp_q[0]});
    else n_pass++;
`ifdef MUL_DISPATCH_CYCLE_COUNT_EN
    n_checks++;
    if (obs_cyc_q.size() != 1 || ref_cyc_q.size() != 1 || obs_cyc_q[0] != ref_cyc_q[0])
      $display("FAIL bp_cycles got=%p exp=%p", obs_cyc_q, ref_cyc_q);
    else n_pass++;
`endif
  endtask

  task automatic test_timeout;
    bit ok;
    int cnt;
    logic [W-1:0] a, b;
    clear_logs();
    m_hang = 1'b1; out_ready = 1'b0;
    push_job(16'd15, 16'd15, 10, ok);
    for (int k = 0; k < 10 && !cpu_start; k++) begin
      @(posedge clk); #1;
    end
    cnt = 0;
    for (int k = 0; k < 2 * TMO && !out_valid; k++) begin
      @(posedge clk); #1;
      cnt++;
    end
    n_checks++;
    if (cnt != TMO + 1) $display("FAIL timeout_latency got=%0d exp=%0d", cnt, TMO + 1); else n_pass++;
    n_checks++;
    if ({out_valid, out_error, out_result} !== {1'b1, 1'b1, 16'd0})
      $display("FAIL timeout_result v=%b err=%b res=%0d exp 1,1,0", out_valid, out_error, out_result);
    else n_pass++;
`ifdef MUL_DISPATCH_CYCLE_COUNT_EN
    n_checks++;
    if (out_cycles !== 16'(TMO - 1)) $display("FAIL timeout_cycles got=%0d exp=%0d", out_cycles, TMO - 1);
    else n_pass++;
`endif
    out_ready = 1'b1;
    @(posedge clk); #1;
    m_hang = 1'b0;
    clear_logs();
    a = W'($urandom_range(0, 255)); b = W'($urandom_range(0, 255));
    push_job(a, b, 20, ok);
    wait_results(1, 200);
    n_checks++;
    if (obs_q.size() != 1 || obs_q[0] !== {1'b0, ref_mul(a, b)})
      $display("FAIL timeout_next count=%0d got=%h exp=%h", obs_q.size(), obs_q.size() ? obs_q[0] : '0, {1'b0, ref_mul(a, b)});
    else n_pass++;
  endtask

  task automatic test_reset_mid;
    bit ok;
    logic [3*W+5:0] got;
    clear_logs();
    out_ready = 1'b1;
    push_job(16'd100, 16'd2, 10, ok);
    push_job(16'd15, 16'd15, 10, ok);
    for (int k = 0; k < 10 && !cpu_start; k++) begin
      @(posedge clk); #1;
    end
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    got = {in_ready, out_valid, out_error, cpu_start, busy, cpu_rst_n, out_result, cpu_operand_a, cpu_operand_b};
    n_checks++;
    if (got !== '0) $display("FAIL midreset_values got=%h exp=0", got); else n_pass++;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    exp_q.delete();
    repeat (60) @(posedge clk);
    #1;
    n_checks++;
    if (obs_q.size() != 0 || busy) $display("FAIL midreset_discard results=%0d busy=%b exp 0,0", obs_q.size(), busy);
    else n_pass++;
    push_job(16'd100, 16'd2, 10, ok);
    wait_results(1, 200);
    n_checks++;
    if (obs_q.size() != 1 || obs_q[0] !== {1'b0, 16'd200})
      $display("FAIL midreset_after count=%0d got=%h exp=%h", obs_q.size(), obs_q.size() ? obs_q[0] : '0, {1'b0, 16'd200});
    else n_pass++;
  endtask

  task automatic test_random;
    bit ok;
    bit stop;
    int accepted;
    clear_logs();
    stop = 1'b0; accepted = 0;
    fork
      begin
        for (int i = 0; i < 12; i++) begin
          repeat ($urandom_range(0, 3)) @(posedge clk);
          #1;
          push_job(W'($urandom_range(0, 255)), W'($urandom_range(0, 255)), 600, ok);
          if (ok) accepted++;
        end
        stop = 1'b1;
      end
      begin
        while (!stop) begin
          @(posedge clk); #1;
          if (!stop) out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    out_ready = 1'b1;
    wait_results(12, 1500);
    n_checks++;
    if (accepted != 12 || obs_q.size() != 12)
      $display("FAIL random_count accepted=%0d results=%0d exp 12,12", accepted, obs_q.size());
    else n_pass++;
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      n_checks++;
      if (obs_q[i] !== {1'b0, exp_q[i]}) $display("FAIL random_result%0d got=%h exp=%h", i, obs_q[i], {1'b0, exp_q[i]});
      else n_pass++;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog sim_time=%0t exp=finish earlier", $time);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mul_job_dispatcher.md
Name: mul_job_dispatcher

Overview:
- Upstream feeder for simple_cpu_top, the ROM-programmed shift-add multiplier CPU.
- Buffers multiply jobs (operand pairs) arriving on a valid/ready stream and launches them one at a time with a start pulse.
- Captures result/done, returns results in order on a valid/ready stream, and pulses the CPU's reset between jobs.
- Per-job timeout so a hung program cannot stall the stream.

Parameters:
- BIT_WIDTH, 16: operand/result width; must match the CPU.
- FIFO_DEPTH, 4: job FIFO entries; power of 2, at least 2.
- TIMEOUT_CYCLES, 500: cycles WAIT tolerates without cpu_done.
- RST_CYCLES, 2: cycles cpu_rst_n is held low after each job.

Ports:
- clk, input, 1: system clock, rising edge.
- rst_n, input, 1: asynchronous active-low reset.
- in_valid, input, 1: job offered.
- in_ready, output, 1: FIFO can accept a job.
- in_a, input, BIT_WIDTH: multiplicand.
- in_b, input, BIT_WIDTH: multiplier.
- out_valid, output, 1: result available.
- out_ready, input, 1: consumer accepts result.
- out_result, output, BIT_WIDTH: product, or 0 on error.
- out_error, output, 1: job timed out.
- busy, output, 1: FSM not IDLE or FIFO non-empty.
- cpu_start, output, 1: start pulse to CPU.
- cpu_operand_a, output, BIT_WIDTH: operand A to CPU.
- cpu_operand_b, output, BIT_WIDTH: operand B to CPU.
- cpu_result, input, BIT_WIDTH: CPU result.
- cpu_done, input, 1: CPU done.
- cpu_rst_n, output, 1: CPU reset, active low.

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-low, rst_n.
- Reset values:
  - FIFO empty; FSM in IDLE; wait counter 0.
  - in_ready=0 while rst_n=0, then 1.
  - out_valid=0, out_result=0, out_error=0, cpu_start=0, cpu_operand_a/b=0, busy=0.
  - cpu_rst_n = rst_n AND (state != CPU_RST), so the CPU is held in reset with the block.
- Reset mid-operation: all queued and in-flight jobs are discarded; no result is emitted.
- Input side:
  - Job is pushed on a rising edge with in_valid && in_ready.
  - in_ready = !full, registered-count based. No bypass: a full FIFO refuses a push even when a pop happens in the same cycle.
  - Push and pop in the same cycle (not full) are both honoured; count is unchanged.
  - Read and write pointers wrap modulo FIFO_DEPTH.
- FSM:
  - IDLE: if the FIFO is non-empty, pop the head, latch it into cpu_operand_a/b, go to LAUNCH. Otherwise stay.
  - LAUNCH (1 cycle): cpu_start=1; clear the wait counter; go to WAIT.
  - WAIT: the counter increments each cycle.
    - cpu_done=1: out_result<=cpu_result, out_error<=0, go to HOLD.
    - Else, counter == TIMEOUT_CYCLES-1: out_result<=0, out_error<=1, go to HOLD.
    - cpu_done and timeout in the same cycle: done wins.
  - HOLD: out_valid=1; out_result/out_error stable. On out_ready, go to CPU_RST.
  - CPU_RST: cpu_rst_n=0 for exactly RST_CYCLES cycles, then SETTLE.
  - SETTLE (1 cycle): cpu_rst_n=1; go to IDLE.
- cpu_operand_a/b hold their value from LAUNCH until the next pop.
- cpu_start is high only in LAUNCH.
- Latency: a job pushed into an empty, idle block at edge N gives cpu_start high in cycle N+2. A job turnaround is CPU compute time + 1 HOLD cycle minimum + RST_CYCLES + 1 SETTLE + 1 IDLE + 1 LAUNCH.
- Results are emitted in acceptance order; exactly one result per accepted job.
- out_valid drops the cycle after the handshake.

Optional Feature:
- Macro: MUL_DISPATCH_CYCLE_COUNT_EN.
- Defined:
  - Adds output out_cycles, 16 bits: the WAIT counter value when cpu_done was sampled. On timeout it is TIMEOUT_CYCLES-1.
  - Captured with out_result; stable through HOLD; 0 on reset.
- Undefined: the port and its register do not exist; all other behaviour is identical.

Test Plan:
- Bench setup: simple_cpu_top with the production program.mem behind the dispatcher.
- Single job: push (3,5) with out_ready=1 → out_result=15, out_error=0. cpu_start high exactly 1 cycle. cpu_rst_n low exactly 2 cycles after the out handshake.
- Back-to-back with full FIFO: out_ready=0, push (7,8),(12,10),(0,5),(5,0),(1,42),(42,1).
  - One job in flight plus 4 queued; in_ready=0 for the 6th push.
  - Release out_ready → results 56,120,0,0,42,42 in order, and the 6th push is accepted after the first pop.
- Output backpressure: push (255,255), hold out_ready=0 for 10 cycles after out_valid → out_valid=1 and out_result=65025 stable throughout; one result only after release.
- Timeout: replace the CPU with a model that has cpu_done tied 0; push (15,15) → out_valid with out_error=1, out_result=0, reached 500 cycles after LAUNCH. The next job, with the real CPU, gives the correct product.
- Reset mid-job: push (100,2) and (15,15), assert rst_n low during WAIT → outputs return to reset values immediately and no result appears. After release, push (100,2) → 200.
- With MUL_DISPATCH_CYCLE_COUNT_EN defined: 3*5 and 255*255 → out_cycles equals cycles from LAUNCH+1 to cpu_done, checked against a bench counter.
